// File: rtl/ks_adder32.sv
// ks_adder32: Kogge-Stone parallel-prefix adder with registered sum/cout/out_valid.
// Define KSA_PIPE_EN to register the prefix tree after level 2 (latency becomes 2).
module ks_adder32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
`ifdef KSA_PIPE_EN
  // Split point after the span-4 level; narrow widths register after the last level.
  localparam int unsigned SPLIT = (LEVELS < 3) ? LEVELS : 3;
`else
  localparam int unsigned SPLIT = LEVELS;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } gp_t;

  // Prefix levels lo..hi-1: black cells at i >= 2d, grey at d <= i < 2d, buffers below d.
  function automatic gp_t prefix(input gp_t x, input int unsigned lo, input int unsigned hi);
    gp_t cur;
    gp_t nxt;
    cur = x;
    for (int unsigned k = lo; k < hi; k++) begin
      nxt = cur;
      for (int unsigned i = (32'd1 << k); i < WIDTH; i++) begin
        nxt.g[i] = cur.g[i] | (cur.p[i] & cur.g[i - (32'd1 << k)]);
        if (i >= (32'd2 << k))
          nxt.p[i] = cur.p[i] & cur.p[i - (32'd1 << k)];
      end
      cur = nxt;
    end
    return cur;
  endfunction

  function automatic logic [WIDTH-1:0] group_g(input gp_t x);
    gp_t r;
    r = prefix(x, SPLIT, LEVELS);
    return r.g;
  endfunction

  gp_t              gp0;
  gp_t              mid;
  gp_t              mid_s;
  logic [WIDTH-1:0] px_s;
  logic             v_s;
  logic [WIDTH-1:0] gf;

  assign gp0 = {a & b, a ^ b};
  assign mid = prefix(gp0, 0, SPLIT);

`ifdef KSA_PIPE_EN
  gp_t              mid_q;
  logic [WIDTH-1:0] px_q;
  logic             v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_q <= '0;
      px_q  <= '0;
      v_q   <= 1'b0;
    end else begin
      mid_q <= mid;
      px_q  <= gp0.p;
      v_q   <= in_valid;
    end
  end

  assign mid_s = mid_q;
  assign px_s  = px_q;
  assign v_s   = v_q;
`else
  assign mid_s = mid;
  assign px_s  = gp0.p;
  assign v_s   = in_valid;
`endif

  assign gf = group_g(mid_s);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;
  logic             vld_q;

  assign sum_d  = px_s ^ {gf[WIDTH-2:0], 1'b0};
  assign cout_d = gf[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      if (v_s) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
      vld_q <= v_s;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_ks_adder32.sv
// Testbench for ks_adder32: directed vectors, hold, mid-flight reset and random traffic
// against a queue-based scoreboard; honours KSA_PIPE_EN for the expected latency.
module tb_ks_adder32;

`ifdef KSA_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        cout;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic        vq[$];
  logic [32:0] held;

  always #5 clk = ~clk;

  ks_adder32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  task automatic model_reset();
    exp_q.delete();
    vq.delete();
    for (int i = 0; i < int'(LAT) - 1; i++) vq.push_back(1'b0);
    held = '0;
  endtask

  task automatic check_out(input string tag, input logic ev);
    if (ev) held = exp_q.pop_front();
    checks++;
    assert (out_valid === ev) else begin
      errors++;
      $error("FAIL %s out_valid got %0b exp %0b", tag, out_valid, ev);
    end
    checks++;
    assert ({cout, sum} === held) else begin
      errors++;
      $error("FAIL %s cout_sum got %h exp %h", tag, {cout, sum}, held);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ia, input logic [31:0] ib, input string tag);
    logic ev;
    @(negedge clk);
    in_valid = v;
    a        = ia;
    b        = ib;
    if (v) exp_q.push_back({1'b0, ia} + {1'b0, ib});
    vq.push_back(v);
    ev = vq.pop_front();
    @(posedge clk);
    #1;
    check_out(tag, ev);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    assert ({out_valid, cout, sum} === 34'd0) else begin
      errors++;
      $error("FAIL reset_state got %h exp 0", {out_valid, cout, sum});
    end
    rst_n = 1'b1;

    step(1'b1, 32'h3a6f36e3, 32'hf6af8732, "vec1");
    step(1'b1, 32'hffffffff, 32'h00000001, "wrap");
    step(1'b1, 32'haaaaaaaa, 32'h55555555, "allprop");
    step(1'b1, 32'hffffffff, 32'hffffffff, "b2b_max");
    step(1'b1, 32'h00000000, 32'h00000000, "b2b_zero");
    step(1'b1, 32'h80000000, 32'h80000000, "msb_carry");
    repeat (3) step(1'b0, 32'h5a5a5a5a, 32'h0f0f0f0f, "hold");
    repeat (LAT - 1) step(1'b0, '0, '0, "drain");

    // Reset lands between clocks while a valid input is being presented.
    step(1'b1, 32'h12345678, 32'h9abcdef0, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hdeadbeef;
    b        = 32'h01020304;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert ({out_valid, cout, sum} === 34'd0) else begin
      errors++;
      $error("FAIL mid_rst got %h exp 0", {out_valid, cout, sum});
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    repeat (LAT + 2) step(1'b0, '0, '0, "post_rst");
    step(1'b1, 32'h00000001, 32'h00000001, "after_rst");

    for (int n = 0; n < 10000; n++)
      step(($urandom_range(0, 3) != 0), $urandom, $urandom, "rand");
    repeat (LAT) step(1'b0, '0, '0, "final");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got %0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_adder32.md
Name: ks_adder32

Overview:
- 32-bit Kogge-Stone parallel-prefix adder with a registered output stage.
- Datapath stages:
  - bitwise generate/propagate;
  - log2(WIDTH) prefix levels of black, grey and buffer cells;
  - sum XOR.
- Used as the fast add primitive in the arithmetic datapath.
- Accepts one operand pair per cycle. Results come out in input order, with a valid flag.

Parameters:
- WIDTH, 32, operand width. Must be a power of two and at least 2. Prefix depth is log2(WIDTH), so 5 levels at the default.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a and b are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- sum  output  WIDTH  registered (a+b) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  sum and cout hold a new result this cycle.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low.
- While rst_n=0: sum=0, cout=0, out_valid=0, and all internal pipeline registers are cleared. Deassertion is sampled on the next rising clk.
- Stage 0 (combinational):
  - p[i]=a[i]^b[i], g[i]=a[i]&b[i].
  - There is no carry-in; the carry into bit 0 is 0.
- Prefix operator: (G,P)∘(G',P') = (G | P&G', P&P').
- Prefix level k, for k=0..log2(WIDTH)-1, span d=2^k:
  - Position i >= 2d: black cell, combining (G,P)[i] with (G,P)[i-d]; produces G and P.
  - Position d <= i < 2d: grey cell, combining with [i-d]; produces G only (P is unneeded).
  - Position i < d: buffer, passes G and P through unchanged.
- After the last level, Gf[i] is the group generate of bits i..0.
- Sum: s[0]=p[0], s[i]=p[i]^Gf[i-1]. cout=Gf[WIDTH-1].
- Output register:
  - On a rising clk with in_valid=1: sum and cout load the new result, and out_valid goes to 1.
  - With in_valid=0: sum and cout hold their previous values, and out_valid goes to 0.
- Latency is 1 cycle from the in_valid edge to out_valid; throughput is 1 per cycle.
- Back-to-back valid inputs produce back-to-back results in input order, with no bubbles.
- Boundaries:
  - Wrap-around: 0xFFFFFFFF+1 gives sum 0, cout 1.
  - The carry chain must resolve across all WIDTH bits within one cycle.
  - Reset asserted mid-operation discards the in-flight result; out_valid stays 0 until a new in_valid.
- There are no X-propagation exceptions: every output is defined after reset.

Optional Feature:
- Macro: KSA_PIPE_EN.
- Defined:
  - A pipeline register stage is inserted after prefix level 2 (span 4). It holds G, P, p and a valid bit.
  - The stage is cleared by rst_n and loads every cycle.
  - Total latency becomes 2 cycles; throughput is still 1 per cycle, and order is preserved.
  - out_valid is the in_valid delayed by 2 cycles.
  - Hold semantics on the output register are unchanged, now keyed on the delayed valid.
- Undefined: purely combinational prefix with latency 1, as described above.

Test Plan:
- Reset then apply a=0x3a6f36e3, b=0xf6af8732, in_valid=1 -> next cycle sum=0x311ebe15, cout=1, out_valid=1. With KSA_PIPE_EN this appears one cycle later.
- Apply a=0xffffffff, b=0x00000001 -> sum=0x00000000, cout=1.
- Apply a=0xaaaaaaaa, b=0x55555555 (all propagate, no generate) -> sum=0xffffffff, cout=0.
- Apply a=0xffffffff, b=0xffffffff, followed back-to-back by a=0, b=0 -> consecutive results 0xfffffffe/cout=1, then 0x00000000/cout=0; out_valid stays high for 2 cycles.
- Apply a valid input, then hold in_valid=0 for 3 cycles -> sum/cout hold the last result and out_valid=0.
- Assert rst_n=0 between two clocks while a result is in flight -> sum=0, cout=0, out_valid=0 immediately, and the discarded result never appears.
- Run 10k random a/b pairs with random in_valid -> every result equals the reference {cout,sum}=a+b at the specified latency.
